operand_fetch_unit: RTL and testbench
=====================================

OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter REG_AW, default 4, GPR address width; return-address register is index 2^REG_AW-1.
REQ-003 SHALL have parameter SB_CW, default 2, per-register scoreboard counter width.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
- Clk  in  1  clock
- Rst  in  1  async active-low reset
- If_Pc_i  in  XLEN  fetched PC
- If_Instr_i  in  32  fetched instruction
- If_Valid_i  in  1  fetch valid
- If_Ready_o  out  1  accept
- Cu_Opcode  out  5  instr[31:27] to control unit
- Cu_Imm  out  1  instr[26]
- Cu_IsRet, Cu_IsSt, Cu_IsImm, Cu_WrRd  in  1 each  control-unit decode, combinational
- Rd_Addr1, Rd_Addr2  out  REG_AW  GPR read addresses
- Rd_Data1, Rd_Data2  in  XLEN  GPR read data, same cycle
- Wb_Valid_i  in  1  writeback strobe
- Wb_Addr_i  in  REG_AW  writeback register
- Wb_Data_i  in  XLEN  writeback data
- Flush_i  in  1  kill held instruction
- Of_Pc_o, Of_A_o, Of_B_o, Of_Op2_o  out  XLEN  EX payload
- Of_Instr_o  out  32  EX instruction
- Of_Rd_o  out  REG_AW  destination
- Of_WrRd_o  out  1  writes destination
- Of_Valid_o  out  1  EX valid
- Of_Ready_i  in  1  EX ready
- Stall_o  out  1  hazard stall indicator

Function
REQ-005 Decode SHALL be combinational from If_Instr_i: rd=[25:22], rs1=[21:18], rs2=[17:14], immediate modifier=[17:16].
REQ-006 Rd_Addr1 SHALL be RA index if Cu_IsRet else rs1; Rd_Addr2 SHALL be rd if Cu_IsSt else rs2.
REQ-007 Immediate SHALL be: modifier 00 sign-extend [15:0]; 01 zero-extend; 10 upper XLEN-16 bits all ones; 11 zero-extend.
REQ-008 Of_A = source1; Of_Op2 = source2; Of_B = immediate if Cu_IsImm else source2.
REQ-009 Scoreboard: one SB_CW-bit counter per register, counting in-flight writers.
REQ-010 Source2 SHALL be used when !Cu_IsImm or Cu_IsSt; source1 always used.
REQ-011 Hazard = a used source has nonzero counter (subject to REQ-020), or Cu_WrRd with rd counter at max.
REQ-012 Stall_o = If_Valid_i && hazard.
REQ-013 If_Ready_o = (!Of_Valid_o || Of_Ready_i) && !hazard && !Flush_i.
REQ-014 Accept = If_Valid_i && If_Ready_o; output register SHALL load payload next edge, latency one cycle.
REQ-015 Of_Valid_o SHALL hold, with payload stable, while !Of_Ready_i; cleared when consumed without new accept.
REQ-016 Counter update per register per cycle: +1 accept with Cu_WrRd to it; -1 Wb_Valid_i to it; -1 flush of held writer to it; simultaneous events SHALL sum.
REQ-017 Writeback to a zero counter SHALL be ignored (no underflow).
REQ-018 Flush_i SHALL clear Of_Valid_o next edge and block accept that cycle; Flush_i with Of_Valid_o low changes nothing.
REQ-019 Cu_Opcode/Cu_Imm/Rd_Addr SHALL be zero when If_Valid_i low.

Reset
REQ-021 Rst low SHALL asynchronously clear all counters, Of_Valid_o and all payload outputs to zero; first accept permitted the cycle after release.

Configuration
REQ-020 OF_FWD_EN defined: a used source with counter==1 and matching Wb_Valid_i/Wb_Addr_i SHALL not be a hazard and SHALL take Wb_Data_i; undefined: any nonzero counter stalls, accept occurs earliest the cycle after writeback.

Verification
REQ-022 ADD r3 writes, next instr reads r3, no OF_FWD_EN -> Stall_o high until writeback cycle, accept one cycle after, Of_A_o = writeback value.
REQ-023 Same with OF_FWD_EN, Wb_Data_i=0x1234 in stall cycle -> accept that cycle, Of_A_o=0x1234 next cycle.
REQ-024 Immediate instr modifier 00, imm 0x8001 -> Of_B_o=0xFFFF8001; modifier 01 -> 0x00008001; modifier 10 -> 0xFFFF8001.
REQ-025 Held writer to r5, Of_Ready_i low, Flush_i pulse -> Of_Valid_o 0 next cycle, r5 counter returns 0, reader of r5 accepted without stall.
REQ-026 Three back-to-back writers to r2 (SB_CW=2) -> fourth writer stalls until one writeback; Rst asserted mid-stall -> all outputs zero immediately.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: instruction decode, GPR read, per-register scoreboard and EX payload register.
// Build option OF_FWD_EN: bypass same-cycle writeback data into a source instead of stalling on it.
module operand_fetch_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4,
  parameter int SB_CW  = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [XLEN-1:0]   If_Pc_i,
  input  logic [31:0]       If_Instr_i,
  input  logic              If_Valid_i,
  output logic              If_Ready_o,
  output logic [4:0]        Cu_Opcode,
  output logic              Cu_Imm,
  input  logic              Cu_IsRet,
  input  logic              Cu_IsSt,
  input  logic              Cu_IsImm,
  input  logic              Cu_WrRd,
  output logic [REG_AW-1:0] Rd_Addr1,
  output logic [REG_AW-1:0] Rd_Addr2,
  input  logic [XLEN-1:0]   Rd_Data1,
  input  logic [XLEN-1:0]   Rd_Data2,
  input  logic              Wb_Valid_i,
  input  logic [REG_AW-1:0] Wb_Addr_i,
  input  logic [XLEN-1:0]   Wb_Data_i,
  input  logic              Flush_i,
  output logic [XLEN-1:0]   Of_Pc_o,
  output logic [XLEN-1:0]   Of_A_o,
  output logic [XLEN-1:0]   Of_B_o,
  output logic [XLEN-1:0]   Of_Op2_o,
  output logic [31:0]       Of_Instr_o,
  output logic [REG_AW-1:0] Of_Rd_o,
  output logic              Of_WrRd_o,
  output logic              Of_Valid_o,
  input  logic              Of_Ready_i,
  output logic              Stall_o
);

  localparam int                NREG    = 1 << REG_AW;
  localparam logic [REG_AW-1:0] RA_IDX  = REG_AW'(NREG - 1);
  localparam logic [SB_CW-1:0]  CNT_MAX = '1;
  localparam logic [SB_CW-1:0]  CNT_ONE = SB_CW'(1);

  logic [REG_AW-1:0] rd, rs1, rs2, raddr1, raddr2;
  logic [1:0]        imm_mod;
  logic [XLEN-1:0]   imm, src1, src2;
  logic              use2, busy1, busy2, fwd1, fwd2, hazard, accept;
  logic [SB_CW-1:0]  sb_cnt [NREG];
  logic [SB_CW-1:0]  sb_nxt [NREG];

  assign rd      = REG_AW'(If_Instr_i[25:22]);
  assign rs1     = REG_AW'(If_Instr_i[21:18]);
  assign rs2     = REG_AW'(If_Instr_i[17:14]);
  assign imm_mod = If_Instr_i[17:16];

  assign raddr1 = Cu_IsRet ? RA_IDX : rs1;
  assign raddr2 = Cu_IsSt ? rd : rs2;

  // Decode outputs are forced to zero while no instruction is presented.
  assign Cu_Opcode = If_Valid_i ? If_Instr_i[31:27] : 5'd0;
  assign Cu_Imm    = If_Valid_i & If_Instr_i[26];
  assign Rd_Addr1  = If_Valid_i ? raddr1 : '0;
  assign Rd_Addr2  = If_Valid_i ? raddr2 : '0;

  always_comb begin
    imm = '0;
    case (imm_mod)
      2'b00:   imm = {{(XLEN-16){If_Instr_i[15]}}, If_Instr_i[15:0]};
      2'b10:   imm = {{(XLEN-16){1'b1}}, If_Instr_i[15:0]};
      default: imm = {{(XLEN-16){1'b0}}, If_Instr_i[15:0]};
    endcase
  end

  assign use2  = !Cu_IsImm || Cu_IsSt;
  assign busy1 = sb_cnt[raddr1] != '0;
  assign busy2 = sb_cnt[raddr2] != '0;

`ifdef OF_FWD_EN
  // Only the last outstanding writer may be bypassed; older writers would leave stale data.
  assign fwd1 = Wb_Valid_i && (Wb_Addr_i == raddr1) && (sb_cnt[raddr1] == CNT_ONE);
  assign fwd2 = use2 && Wb_Valid_i && (Wb_Addr_i == raddr2) && (sb_cnt[raddr2] == CNT_ONE);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign src1 = fwd1 ? Wb_Data_i : Rd_Data1;
  assign src2 = fwd2 ? Wb_Data_i : Rd_Data2;

  assign hazard = (busy1 && !fwd1) || (use2 && busy2 && !fwd2)
                || (Cu_WrRd && (sb_cnt[rd] == CNT_MAX));

  // Handshake: a beat transfers on an edge where valid && ready; the producer keeps valid and
  // payload stable until then, and ready never depends on the same-side valid.
  assign If_Ready_o = (!Of_Valid_o || Of_Ready_i) && !hazard && !Flush_i;
  assign accept     = If_Valid_i && If_Ready_o;
  assign Stall_o    = If_Valid_i && hazard;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sb_nxt[i] = sb_cnt[i];
      if (accept && Cu_WrRd && (rd == REG_AW'(i)))
        sb_nxt[i] = sb_nxt[i] + CNT_ONE;
      if (Wb_Valid_i && (Wb_Addr_i == REG_AW'(i)) && (sb_cnt[i] != '0))
        sb_nxt[i] = sb_nxt[i] - CNT_ONE;
      if (Flush_i && Of_Valid_o && Of_WrRd_o && (Of_Rd_o == REG_AW'(i)))
        sb_nxt[i] = sb_nxt[i] - CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) sb_cnt[i] <= sb_nxt[i];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Of_Valid_o <= 1'b0;
      Of_Pc_o    <= '0;
      Of_A_o     <= '0;
      Of_B_o     <= '0;
      Of_Op2_o   <= '0;
      Of_Instr_o <= '0;
      Of_Rd_o    <= '0;
      Of_WrRd_o  <= 1'b0;
    end else if (Flush_i) begin
      Of_Valid_o <= 1'b0;
    end else if (accept) begin
      Of_Valid_o <= 1'b1;
      Of_Pc_o    <= If_Pc_i;
      Of_A_o     <= src1;
      Of_B_o     <= Cu_IsImm ? imm : src2;
      Of_Op2_o   <= src2;
      Of_Instr_o <= If_Instr_i;
      Of_Rd_o    <= rd;
      Of_WrRd_o  <= Cu_WrRd;
    end else if (Of_Ready_i) begin
      Of_Valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit: scenario tasks plus an expected-payload queue drained at EX.
// Expectations that differ with forwarding are selected by OF_FWD_EN, matching the RTL build.
module tb_operand_fetch_unit;
  localparam int EW = 4 * 32 + 32 + 4 + 1;

  logic        Clk, Rst;
  logic [31:0] If_Pc_i, If_Instr_i;
  logic        If_Valid_i, If_Ready_o;
  logic [4:0]  Cu_Opcode;
  logic        Cu_Imm, Cu_IsRet, Cu_IsSt, Cu_IsImm, Cu_WrRd;
  logic [3:0]  Rd_Addr1, Rd_Addr2;
  logic [31:0] Rd_Data1, Rd_Data2;
  logic        Wb_Valid_i;
  logic [3:0]  Wb_Addr_i;
  logic [31:0] Wb_Data_i;
  logic        Flush_i;
  logic [31:0] Of_Pc_o, Of_A_o, Of_B_o, Of_Op2_o, Of_Instr_o;
  logic [3:0]  Of_Rd_o;
  logic        Of_WrRd_o, Of_Valid_o, Of_Ready_i, Stall_o;

  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  operand_fetch_unit dut (
    .Clk(Clk), .Rst(Rst),
    .If_Pc_i(If_Pc_i), .If_Instr_i(If_Instr_i), .If_Valid_i(If_Valid_i), .If_Ready_o(If_Ready_o),
    .Cu_Opcode(Cu_Opcode), .Cu_Imm(Cu_Imm),
    .Cu_IsRet(Cu_IsRet), .Cu_IsSt(Cu_IsSt), .Cu_IsImm(Cu_IsImm), .Cu_WrRd(Cu_WrRd),
    .Rd_Addr1(Rd_Addr1), .Rd_Addr2(Rd_Addr2), .Rd_Data1(Rd_Data1), .Rd_Data2(Rd_Data2),
    .Wb_Valid_i(Wb_Valid_i), .Wb_Addr_i(Wb_Addr_i), .Wb_Data_i(Wb_Data_i), .Flush_i(Flush_i),
    .Of_Pc_o(Of_Pc_o), .Of_A_o(Of_A_o), .Of_B_o(Of_B_o), .Of_Op2_o(Of_Op2_o),
    .Of_Instr_o(Of_Instr_o), .Of_Rd_o(Of_Rd_o), .Of_WrRd_o(Of_WrRd_o),
    .Of_Valid_o(Of_Valid_o), .Of_Ready_i(Of_Ready_i), .Stall_o(Stall_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  // ---------------- register file model ----------------
  function automatic logic [31:0] rfv(input logic [3:0] i);
    return {20'hA5A50, i, 4'h0, i};
  endfunction

  logic [31:0] rf [16];
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= rfv(4'(i));
    end else if (Wb_Valid_i) begin
      rf[Wb_Addr_i] <= Wb_Data_i;
    end
  end
  assign Rd_Data1 = rf[Rd_Addr1];
  assign Rd_Data2 = rf[Rd_Addr2];

  // ---------------- instruction builders / immediate model ----------------
  function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [3:0] rd, rs1, rs2);
    return {op, 1'b0, rd, rs1, rs2, 14'h0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [3:0] rd, rs1,
                                       input logic [1:0] md, input logic [15:0] v);
    return {op, 1'b1, rd, rs1, md, v};
  endfunction

  function automatic logic [31:0] imm_model(input logic [1:0] md, input logic [15:0] v);
    if (md == 2'b00) return {{16{v[15]}}, v};
    else if (md == 2'b10) return {16'hFFFF, v};
    else return {16'h0000, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    If_Valid_i = 1'b0; If_Instr_i = '0; If_Pc_i = '0;
    Cu_IsRet = 1'b0; Cu_IsSt = 1'b0; Cu_IsImm = 1'b0; Cu_WrRd = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, ins, input logic rt, st, im, wr);
    If_Pc_i = pc; If_Instr_i = ins; If_Valid_i = 1'b1;
    Cu_IsRet = rt; Cu_IsSt = st; Cu_IsImm = im; Cu_WrRd = wr;
    #1;
  endtask

  // One cycle: sample at negedge, drain scoreboard on an EX transfer, return at posedge+1.
  task automatic step(output logic acc);
    logic [EW-1:0] got, exp;
    @(negedge Clk);
    acc = If_Valid_i && If_Ready_o;
    if (Of_Valid_o && Of_Ready_i) begin
      got = {Of_Pc_o, Of_A_o, Of_B_o, Of_Op2_o, Of_Instr_o, Of_Rd_o, Of_WrRd_o};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected got=%h exp=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL sb_payload got=%h exp=%h", got, exp);
        end
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic issue(input logic [31:0] pc, ins, input logic rt, st, im, wr,
                       input logic [31:0] ea, eb, eop2, input int max_wait, input string nm);
    logic acc;
    int n;
    drive(pc, ins, rt, st, im, wr);
    acc = 1'b0;
    n = 0;
    while (!acc && n < max_wait) begin
      step(acc);
      n++;
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL %s accept got=none_in_%0d exp=accepted", nm, max_wait);
    end else begin
      exp_q.push_back({pc, ea, eb, eop2, ins, ins[25:22], wr});
    end
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Rst = 1'b0; Of_Ready_i = 1'b1; Flush_i = 1'b0;
    Wb_Valid_i = 1'b0; Wb_Addr_i = '0; Wb_Data_i = '0;
    idle();
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if (Of_Valid_o !== 1'b0 || Stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got=%b/%b exp=0/0", Of_Valid_o, Stall_o);
    end
    vectors++;
    if ({Of_Pc_o, Of_A_o, Of_B_o, Of_Op2_o, Of_Instr_o, Of_Rd_o, Of_WrRd_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_payload got=%h/%h/%h exp=0", Of_Pc_o, Of_A_o, Of_Instr_o);
    end
    Rst = 1'b1;
    If_Instr_i = mk_i(5'h15, 4'd9, 4'd10, 2'b11, 16'h1234);
    #1;
    vectors++;
    if (Cu_Opcode !== 5'd0 || Cu_Imm !== 1'b0 || Rd_Addr1 !== 4'd0 || Rd_Addr2 !== 4'd0) begin
      miscompares++;
      $display("FAIL idle_decode got=%h/%b/%h/%h exp=0/0/0/0", Cu_Opcode, Cu_Imm, Rd_Addr1, Rd_Addr2);
    end
    vectors++;
    if (If_Ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready got=%b exp=1", If_Ready_o);
    end
    idle();
  endtask

  task automatic test_decode();
    logic [31:0] ins;
    ins = mk_r(5'h03, 4'd4, 4'd8, 4'd9);
    drive(32'h100, ins, 0, 0, 0, 0);
    vectors++;
    if (Cu_Opcode !== 5'h03 || Cu_Imm !== 1'b0 || Rd_Addr1 !== 4'd8 || Rd_Addr2 !== 4'd9) begin
      miscompares++;
      $display("FAIL decode_reg got=%h/%b/%h/%h exp=03/0/8/9", Cu_Opcode, Cu_Imm, Rd_Addr1, Rd_Addr2);
    end
    issue(32'h100, ins, 0, 0, 0, 0, rfv(8), rfv(9), rfv(9), 1, "decode_reg");

    ins = mk_r(5'h04, 4'd0, 4'd1, 4'd2);
    drive(32'h104, ins, 1, 0, 0, 0);
    vectors++;
    if (Rd_Addr1 !== 4'd15) begin
      miscompares++;
      $display("FAIL decode_ret got=%h exp=f", Rd_Addr1);
    end
    issue(32'h104, ins, 1, 0, 0, 0, rfv(15), rfv(2), rfv(2), 1, "decode_ret");

    ins = mk_i(5'h05, 4'd6, 4'd8, 2'b01, 16'h0040);
    drive(32'h108, ins, 0, 1, 1, 0);
    vectors++;
    if (Rd_Addr2 !== 4'd6 || Cu_Imm !== 1'b1) begin
      miscompares++;
      $display("FAIL decode_store got=%h/%b exp=6/1", Rd_Addr2, Cu_Imm);
    end
    issue(32'h108, ins, 0, 1, 1, 0, rfv(8), 32'h0000_0040, rfv(6), 1, "decode_store");
  endtask

  task automatic test_immediate();
    logic [1:0]  mods [6];
    logic [15:0] vals [6];
    logic [31:0] exps [6];
    logic [31:0] ins;
    mods = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    vals = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF, 16'h7FFF};
    exps = '{32'hFFFF8001, 32'h00008001, 32'hFFFF8001, 32'h00008001, 32'h00007FFF, 32'hFFFF7FFF};
    for (int i = 0; i < 6; i++) begin
      ins = mk_i(5'h08, 4'd0, 4'd9, mods[i], vals[i]);
      issue(32'h200 + 32'(4 * i), ins, 0, 0, 1, 0, rfv(9), exps[i], rfv(ins[17:14]), 1, "imm");
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    step(acc);
    Of_Ready_i = 1'b0;
    issue(32'h400, mk_r(5'h07, 4'd0, 4'd8, 4'd9), 0, 0, 0, 0, rfv(8), rfv(9), rfv(9), 2, "bp_first");
    drive(32'h404, mk_r(5'h07, 4'd0, 4'd10, 4'd11), 0, 0, 0, 0);
    vectors++;
    if (If_Ready_o !== 1'b0 || Stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready got=%b/%b exp=0/0", If_Ready_o, Stall_o);
    end
    for (int i = 0; i < 2; i++) begin
      step(acc);
      vectors++;
      if (acc !== 1'b0 || Of_Valid_o !== 1'b1 || Of_Pc_o !== 32'h400) begin
        miscompares++;
        $display("FAIL bp_hold got=%b/%b/%h exp=0/1/400", acc, Of_Valid_o, Of_Pc_o);
      end
    end
    Of_Ready_i = 1'b1;
    #1;
    step(acc);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got=%b exp=1", acc);
    end else begin
      exp_q.push_back({32'h404, rfv(10), rfv(11), rfv(11), mk_r(5'h07, 4'd0, 4'd10, 4'd11), 4'd0, 1'b0});
    end
    idle();
  endtask

  task automatic test_raw_stall();
    logic acc;
    issue(32'h300, mk_r(5'h01, 4'd3, 4'd1, 4'd2), 0, 0, 0, 1, rfv(1), rfv(2), rfv(2), 1, "raw_writer");
    drive(32'h304, mk_r(5'h01, 4'd4, 4'd3, 4'd1), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (Stall_o !== 1'b1 || If_Ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL raw_stall got=%b/%b exp=1/0", Stall_o, If_Ready_o);
      end
      step(acc);
    end
    Wb_Valid_i = 1'b1; Wb_Addr_i = 4'd3; Wb_Data_i = 32'h0000_1234;
    #1;
`ifdef OF_FWD_EN
    vectors++;
    if (Stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_no_stall got=%b exp=0", Stall_o);
    end
    step(acc);
    Wb_Valid_i = 1'b0;
`else
    vectors++;
    if (Stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_wb_cycle got=%b exp=1", Stall_o);
    end
    step(acc);
    Wb_Valid_i = 1'b0;
    #1;
    vectors++;
    if (acc !== 1'b0 || Stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_after_wb got=%b/%b exp=0/0", acc, Stall_o);
    end
    step(acc);
`endif
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_accept got=%b exp=1", acc);
    end else begin
      exp_q.push_back({32'h304, 32'h0000_1234, rfv(1), rfv(1), mk_r(5'h01, 4'd4, 4'd3, 4'd1), 4'd4, 1'b0});
    end
    idle();
  endtask

  task automatic test_wb_underflow();
    logic acc;
    Wb_Valid_i = 1'b1; Wb_Addr_i = 4'd7; Wb_Data_i = 32'h0000_6666;
    step(acc);
    Wb_Valid_i = 1'b0;
    issue(32'h340, mk_r(5'h02, 4'd7, 4'd8, 4'd9), 0, 0, 0, 1, rfv(8), rfv(9), rfv(9), 1, "uf_writer");
    drive(32'h344, mk_r(5'h02, 4'd0, 4'd7, 4'd8), 0, 0, 0, 0);
    vectors++;
    if (Stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_zero_ignored got=%b exp=1", Stall_o);
    end
    idle();
    Wb_Valid_i = 1'b1; Wb_Addr_i = 4'd7; Wb_Data_i = 32'h0000_7777;
    step(acc);
    Wb_Valid_i = 1'b0;
    issue(32'h344, mk_r(5'h02, 4'd0, 4'd7, 4'd8), 0, 0, 0, 0, 32'h0000_7777, rfv(8), rfv(8), 1, "uf_reader");
  endtask

  task automatic test_flush();
    logic acc;
    logic [EW-1:0] dropped;
    step(acc);
    Of_Ready_i = 1'b0;
    issue(32'h500, mk_r(5'h02, 4'd5, 4'd8, 4'd9), 0, 0, 0, 1, rfv(8), rfv(9), rfv(9), 1, "flush_writer");
    step(acc);
    vectors++;
    if (Of_Valid_o !== 1'b1 || Of_Pc_o !== 32'h500) begin
      miscompares++;
      $display("FAIL flush_held got=%b/%h exp=1/500", Of_Valid_o, Of_Pc_o);
    end
    Flush_i = 1'b1;
    step(acc);
    Flush_i = 1'b0;
    vectors++;
    if (Of_Valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear got=%b exp=0", Of_Valid_o);
    end
    dropped = exp_q.pop_back();
    Of_Ready_i = 1'b1;
    issue(32'h504, mk_r(5'h02, 4'd0, 4'd5, 4'd5), 0, 0, 0, 0, rfv(5), rfv(5), rfv(5), 1, "flush_reader");
  endtask

  task automatic test_random();
    logic [3:0]  rs1, rs2;
    logic [1:0]  md;
    logic [15:0] v;
    logic [31:0] ins, eb, eop2;
    for (int i = 0; i < 8; i++) begin
      rs1 = 4'($urandom_range(8, 14));
      rs2 = 4'($urandom_range(8, 14));
      md  = 2'($urandom_range(0, 3));
      v   = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) begin
        ins = mk_i(5'($urandom_range(0, 31)), 4'd0, rs1, md, v);
        eb = imm_model(md, v);
        eop2 = rfv(ins[17:14]);
        issue(32'h800 + 32'(4 * i), ins, 0, 0, 1, 0, rfv(rs1), eb, eop2, 1, "rand_imm");
      end else begin
        ins = mk_r(5'($urandom_range(0, 31)), 4'd0, rs1, rs2);
        issue(32'h800 + 32'(4 * i), ins, 0, 0, 0, 0, rfv(rs1), rfv(rs2), rfv(rs2), 1, "rand_reg");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [31:0] w;
    w = mk_r(5'h03, 4'd2, 4'd0, 4'd0);
    for (int k = 0; k < 3; k++)
      issue(32'h600 + 32'(4 * k), w, 0, 0, 0, 1, rfv(0), rfv(0), rfv(0), 1, "b2b_writer");
    drive(32'h60C, w, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (Stall_o !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_full_stall got=%b exp=1", Stall_o);
      end
      step(acc);
    end
    Wb_Valid_i = 1'b1; Wb_Addr_i = 4'd2; Wb_Data_i = 32'h0000_BEEF;
    #1;
    vectors++;
    if (Stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_wb_cycle got=%b exp=1", Stall_o);
    end
    step(acc);
    Wb_Valid_i = 1'b0;
    #1;
    step(acc);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_fourth_accept got=%b exp=1", acc);
    end else begin
      exp_q.push_back({32'h60C, rfv(0), rfv(0), rfv(0), w, 4'd2, 1'b1});
    end
    drive(32'h610, w, 0, 0, 0, 1);
    step(acc);
    vectors++;
    if (acc !== 1'b0 || Stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_fifth_stall got=%b/%b exp=0/1", acc, Stall_o);
    end
    #2 Rst = 1'b0;
    #1;
    vectors++;
    if (Of_Valid_o !== 1'b0 || Stall_o !== 1'b0
        || {Of_Pc_o, Of_A_o, Of_B_o, Of_Op2_o, Of_Instr_o, Of_Rd_o, Of_WrRd_o} !== '0) begin
      miscompares++;
      $display("FAIL midstall_reset got=%b/%b/%h/%h exp=0/0/0/0", Of_Valid_o, Stall_o, Of_Pc_o, Of_Instr_o);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pre_reset_drain got=%0d exp=0", exp_q.size());
    end
    idle();
    step(acc);
    Rst = 1'b1;
    issue(32'h700, mk_r(5'h03, 4'd0, 4'd2, 4'd2), 0, 0, 0, 0, rfv(2), rfv(2), rfv(2), 1, "post_reset");
  endtask

  initial begin
    logic acc;
    test_reset();
    test_decode();
    test_immediate();
    test_backpressure();
    test_raw_stall();
    test_wb_underflow();
    test_flush();
    test_random();
    test_back_to_back();
    for (int i = 0; i < 3; i++) step(acc);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
